// File: rtl/aes_key_schedule_iter.sv
// Iterative AES-128/192/256 key schedule: one 32-bit schedule word per cycle into a
// 60-word store, with a registered round-key read port and a rounds-ready count.
module aes_key_schedule_iter #(
    parameter int MAX_NK = 8,
    parameter int RIDX_W = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_v_i,
    output logic              start_ready_o,
    input  logic [1:0]        mode_i,
    input  logic [0:255]      key_i,
    output logic              err_o,
    output logic [RIDX_W-1:0] rounds_ready_o,
    output logic              keys_valid_o,
    input  logic [RIDX_W-1:0] rk_idx_i,
    output logic [0:127]      rk_o
);

    localparam int STORE_W = 4 * (MAX_NK + 7);
    localparam int WIDX_W  = $clog2(STORE_W + 1);
    localparam int RD_W    = RIDX_W + 2;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // NOTE: functions and always_comb use blocking '=' for temporaries; only
    // always_ff state uses non-blocking '<='.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // S-box as inverse x^254 in GF(2^8) (0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 0; k < 7; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    logic [31:0]       store [STORE_W];
    state_t            state, state_next;
    logic [3:0]        nk_q;
    logic [3:0]        j_q;
    logic [WIDX_W-1:0] i_q;
    logic [WIDX_W-1:0] last_q;
    logic [7:0]        rcon_q;
    logic              err_q;
    logic              kv_q;
    logic [RIDX_W-1:0] rr_q;
    logic [127:0]      rk_q;

    logic [3:0]        start_nk;
    logic              mode_ok;
    logic              accept, load, reject;
    logic [WIDX_W-1:0] prev_idx, back_idx, words_done;
    logic [31:0]       prev_word, back_word, rot_word, sub_in, sub_out, t_word, new_word;
    logic [127:0]      rd_data;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        start_nk = 4'd0;
        case (mode_i)
            2'b00:   start_nk = 4'd4;
            2'b01:   start_nk = 4'd6;
            2'b10:   start_nk = 4'd8;
            default: start_nk = 4'd0;
        endcase
        mode_ok = (start_nk != 4'd0) && (int'(start_nk) <= MAX_NK);
    end

    assign start_ready_o = (state != EXPAND);
    assign accept        = start_v_i && start_ready_o;
    assign load          = accept && mode_ok;
    assign reject        = accept && !mode_ok;

    assign prev_idx   = i_q - WIDX_W'(1);
    assign back_idx   = i_q - WIDX_W'(nk_q);
    assign words_done = i_q + WIDX_W'(1);
    assign prev_word  = store[prev_idx];
    assign back_word  = store[back_idx];

    // One shared SubWord serves both the RotWord (j==0) and the AES-256 mid-key step.
    always_comb begin
        rot_word = {prev_word[23:0], prev_word[31:24]};
        sub_in   = (j_q == 4'd0) ? rot_word : prev_word;
        sub_out  = sub_word(sub_in);
        if (j_q == 4'd0)                        t_word = sub_out ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && j_q == 4'd4)   t_word = sub_out;
        else                                    t_word = prev_word;
        new_word = back_word ^ t_word;
    end

    // Out-of-range indices read as zero so nothing undefined leaves the store.
    always_comb begin
        rd_data = '0;
        for (int q = 0; q < 4; q++) begin
            logic [RD_W-1:0] rd_idx;
            rd_idx = {rk_idx_i, 2'b00} + RD_W'(q);
            if (int'(rd_idx) < STORE_W) rd_data[127-32*q -: 32] = store[rd_idx];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = EXPAND;
            EXPAND:  if (i_q == last_q) state_next = DONE;
            DONE:    if (load) state_next = EXPAND;
                     else if (reject) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            nk_q   <= 4'd4;
            j_q    <= 4'd0;
            i_q    <= '0;
            last_q <= '0;
            rcon_q <= 8'h01;
            err_q  <= 1'b0;
            kv_q   <= 1'b0;
            rr_q   <= '0;
            rk_q   <= '0;
        end else begin
            err_q <= reject;
            rk_q  <= rd_data;
            if (load) begin
                nk_q   <= start_nk;
                i_q    <= WIDX_W'(start_nk);
                last_q <= WIDX_W'({start_nk, 2'b00}) + WIDX_W'(27);
                j_q    <= 4'd0;
                rcon_q <= 8'h01;
                rr_q   <= RIDX_W'(start_nk >> 2);
                kv_q   <= 1'b0;
            end else if (state == EXPAND) begin
                i_q  <= words_done;
                j_q  <= (j_q == nk_q - 4'd1) ? 4'd0 : j_q + 4'd1;
                rr_q <= RIDX_W'(words_done >> 2);
                if (j_q == 4'd0) rcon_q <= xtime(rcon_q);
            end else if (state == DONE) begin
                kv_q <= 1'b1;
            end
        end
    end

    // NOTE: the word store is deliberately not reset; the rounds-ready count
    // alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (load) begin
                for (int k = 0; k < MAX_NK; k++)
                    if (4'(k) < start_nk) store[k] <= key_i[32*k +: 32];
            end else if (state == EXPAND) begin
                store[i_q] <= new_word;
            end
        end
    end

    assign err_o          = err_q;
    assign keys_valid_o   = kv_q;
    assign rounds_ready_o = rr_q;
    assign rk_o           = rk_q;

endmodule

// File: tb/tb_aes_key_schedule_iter.sv
// Scoreboard bench for aes_key_schedule_iter: a FIPS-197 style reference model feeds
// expected round keys, latencies and error pulses to a negedge monitor.
module tb_aes_key_schedule_iter;

    localparam int RIDX_W = 4;

    localparam logic [127:0] K128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [191:0] K192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] RK12_192 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK14_256 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [7:0]   RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                             8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b1;
    logic              start_v_i = 1'b0;
    logic              start_ready_o;
    logic [1:0]        mode_i = 2'b00;
    logic [0:255]      key_i = '0;
    logic              err_o;
    logic [RIDX_W-1:0] rounds_ready_o;
    logic              keys_valid_o;
    logic [RIDX_W-1:0] rk_idx_i = '0;
    logic [0:127]      rk_o;

    aes_key_schedule_iter #(.MAX_NK(8), .RIDX_W(RIDX_W)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .start_v_i      (start_v_i),
        .start_ready_o  (start_ready_o),
        .mode_i         (mode_i),
        .key_i          (key_i),
        .err_o          (err_o),
        .rounds_ready_o (rounds_ready_o),
        .keys_valid_o   (keys_valid_o),
        .rk_idx_i       (rk_idx_i),
        .rk_o           (rk_o)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct { int cyc; logic [127:0] val; int idx; } rd_t;
    typedef struct { int acc; int lat; int nk; int nr; } run_t;

    rd_t         exp_rd[$];
    run_t        exp_valid[$];
    int          exp_err[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          cur_acc = 0;
    int          cur_nk = 4;
    logic [7:0]  sbox_t [256];
    logic [31:0] mw [60];

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // S-box table built by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic model_expand(input int nk, input logic [255:0] k);
        logic [31:0] t;
        int          w_tot;
        w_tot = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) mw[i] = k[255-32*i -: 32];
        for (int i = nk; i < w_tot; i++) begin
            t = mw[i-1];
            if (i % nk == 0)                  t = sub_w({t[23:0], t[31:24]}) ^ {RCON[i/nk], 24'h0};
            else if (nk == 8 && i % nk == 4)  t = sub_w(t);
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] model_rk(input int idx);
        return {mw[4*idx], mw[4*idx+1], mw[4*idx+2], mw[4*idx+3]};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start(input logic [1:0] m, input logic [255:0] k);
        cur_nk  = 4 + 2 * int'(m);
        cur_acc = cyc + 1;
        model_expand(cur_nk, k);
        exp_valid.push_back('{acc: cur_acc, lat: 1 + 4 * (cur_nk + 7) - cur_nk,
                              nk: cur_nk, nr: cur_nk + 6});
        start_v_i = 1'b1;
        mode_i    = m;
        key_i     = k;
        tick();
        start_v_i = 1'b0;
    endtask

    task automatic read(input int idx, input logic [127:0] val);
        rk_idx_i = RIDX_W'(idx);
        exp_rd.push_back('{cyc: cyc + 1, val: val, idx: idx});
        tick();
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!keys_valid_o && n < 100) begin
            tick();
            n++;
        end
        check("kv_timeout", keys_valid_o, 1);
    endtask

    task automatic run_random(input logic [1:0] m);
        logic [255:0] k;
        int           n, words, rr, w_tot, nr, off, idx;
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start(m, k);
        w_tot = 4 * (cur_nk + 7);
        nr    = cur_nk + 6;
        n     = 0;
        while (!keys_valid_o && n < 100) begin
            words = cur_nk + (cyc - cur_acc);
            if (words > w_tot) words = w_tot;
            rr = words / 4;
            if ($urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, rr - 1);
                read(idx, model_rk(idx));
            end else begin
                tick();
            end
            n++;
        end
        check("kv_timeout_rand", keys_valid_o, 1);
        off = $urandom_range(0, nr);
        for (int q = 0; q <= nr; q++) begin
            idx = (off + q) % (nr + 1);
            read(idx, model_rk(idx));
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    initial begin
        rd_t  r;
        run_t v;
        int   e, words;
        logic kv_prev;
        kv_prev = 1'b0;
        forever begin
            @(negedge clk_i);
            if (exp_rd.size() > 0 && exp_rd[0].cyc == cyc) begin
                r = exp_rd.pop_front();
                check($sformatf("rk_idx%0d", r.idx), rk_o, r.val);
            end
            if (exp_valid.size() > 0 && cyc >= exp_valid[0].acc) begin
                v = exp_valid[0];
                words = v.nk + (cyc - v.acc);
                if (words > 4 * (v.nr + 1)) words = 4 * (v.nr + 1);
                check("rounds_ready", rounds_ready_o, words / 4);
            end
            if (keys_valid_o && !kv_prev) begin
                if (exp_valid.size() == 0) check("kv_unexpected", keys_valid_o, 0);
                else begin
                    v = exp_valid.pop_front();
                    check("kv_latency", cyc - v.acc, v.lat);
                end
            end
            kv_prev = keys_valid_o;
            if (err_o) begin
                if (exp_err.size() == 0) check("err_unexpected", err_o, 0);
                else begin
                    e = exp_err.pop_front();
                    check("err_cycle", cyc, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        build_sbox();

        repeat (3) tick();
        check("rst_start_ready", start_ready_o, 1);
        check("rst_err", err_o, 0);
        check("rst_rounds_ready", rounds_ready_o, 0);
        check("rst_keys_valid", keys_valid_o, 0);
        check("rst_rk", rk_o, 0);
        reset_i = 1'b0;
        tick();

        // Invalid mode: one-cycle error pulse, nothing else moves.
        start_v_i = 1'b1;
        mode_i    = 2'b11;
        exp_err.push_back(cyc + 1);
        tick();
        start_v_i = 1'b0;
        check("bad_mode_kv", keys_valid_o, 0);
        check("bad_mode_ready", start_ready_o, 1);
        check("bad_mode_rr", rounds_ready_o, 0);
        repeat (2) tick();

        // AES-128 known answer with a blocked second start and an early read.
        start(2'b00, {K128, 128'h0});
        check("busy_ready", start_ready_o, 0);
        start_v_i = 1'b1;
        mode_i    = 2'b10;
        key_i     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        tick();
        start_v_i = 1'b0;
        n = 0;
        while (rounds_ready_o < 2 && n < 20) begin
            tick();
            n++;
        end
        check("rr_reach2", rounds_ready_o >= 2, 1);
        read(1, RK1_128);
        wait_valid();
        read(10, RK10_128);
        read(0, K128);

        // AES-192 known answer, re-keyed straight from DONE.
        start(2'b01, {K192, 64'h0123456789abcdef});
        wait_valid();
        read(12, RK12_192);

        // AES-256 known answer.
        start(2'b10, K256);
        check("rr_after_load_256", rounds_ready_o, 2);
        wait_valid();
        read(14, RK14_256);
        read(0, K256[255:128]);

        // Reset 20 cycles into an AES-256 run, with a start held during reset.
        start(2'b10, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        repeat (19) tick();
        exp_valid.delete();
        reset_i   = 1'b1;
        start_v_i = 1'b1;
        mode_i    = 2'b00;
        tick();
        reset_i   = 1'b0;
        start_v_i = 1'b0;
        check("midrst_kv", keys_valid_o, 0);
        check("midrst_rr", rounds_ready_o, 0);
        check("midrst_ready", start_ready_o, 1);
        tick();
        check("midrst_no_start", rounds_ready_o, 0);
        start(2'b00, {K128, 128'hfeedface_0badf00d_12345678_9abcdef0});
        wait_valid();
        read(10, RK10_128);

        // Randomised keys and modes with early reads during expansion.
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
            run_random(2'($urandom_range(0, 2)));
        end

        repeat (3) tick();
        check("rd_queue_drained", exp_rd.size(), 0);
        check("valid_queue_drained", exp_valid.size(), 0);
        check("err_queue_drained", exp_err.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule_iter.md
Name: aes_key_schedule_iter

Overview:
- Iterative, run-time-configurable AES key schedule supporting AES-128, AES-192 and AES-256.
- Computes one 32-bit schedule word per cycle into an internal 60-word store.
- Serves round keys through a registered read port, and exposes a rounds-ready count so the cipher datapath can start before expansion finishes.
- Successor to the fixed 256-bit unrolled expansion; sits between the key source and the multicycle round datapath.

Parameters:
- MAX_NK, 8, largest supported key length in 32-bit words (4, 6 or 8). Modes with Nk > MAX_NK are rejected; the store is sized to 4*(MAX_NK+7) words.
- RIDX_W, 4, width of the round-key index.

Ports:
- clk_i  input  1  clock
- reset_i  input  1  synchronous active-high reset
- start_v_i  input  1  start request; valid with key_i and mode_i
- start_ready_o  output  1  high when a start will be accepted
- mode_i  input  2  key size: 00=128, 01=192, 10=256, 11=invalid
- key_i  input  [0:255]  cipher key, MSB-first; AES-128 uses [0:127], AES-192 uses [0:191]
- err_o  output  1  one-cycle pulse on a rejected start
- rounds_ready_o  output  RIDX_W  number of complete round keys available (0..Nr+1)
- keys_valid_o  output  1  full schedule complete
- rk_idx_i  input  RIDX_W  round-key index to read
- rk_o  output  [0:127]  round key rk_idx_i, registered (1-cycle read latency)

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk_i, reset_i).
- Reset values:
  - state=IDLE, start_ready_o=1, err_o=0, rounds_ready_o=0, keys_valid_o=0, rk_o=0, Rcon=8'h01.
  - Word store contents are not cleared.
- Derived per mode: Nk=4/6/8, Nr=10/12/14, total words W=4*(Nr+1)=44/52/60.
- Handshake:
  - A start is accepted on an edge where start_v_i & start_ready_o.
  - start_ready_o=1 in IDLE and DONE, 0 in EXPAND.
  - start_v_i is ignored while in EXPAND.
- Invalid mode (11, or Nk>MAX_NK) on a start: err_o=1 for the next cycle, state becomes IDLE, outputs are otherwise unchanged.
- FSM:
  - IDLE -> EXPAND on a valid start. On the accept edge, words 0..Nk-1 are written from key_i, i=Nk, j=0, Rcon=01, and mode is latched.
  - EXPAND: each edge writes w[i]=w[i-Nk]^t, then i++ and j=(j==Nk-1)?0:j+1 (no divider). t is:
    - j==0: SubWord(RotWord(w[i-1]))^{Rcon,24'h0}; Rcon <= xtime(Rcon), i.e. reduction by 0x1b.
    - Nk==8 && j==4: SubWord(w[i-1]).
    - otherwise: w[i-1].
  - EXPAND -> DONE on the edge writing word W-1.
  - DONE -> EXPAND on a valid start (re-key). keys_valid_o and rounds_ready_o take their new-load values on the same edge.
- Latency: keys_valid_o rises 1+(W-Nk) edges after the accept edge, i.e. 41/47/53 cycles. It stays high in DONE.
- rounds_ready_o:
  - Registered value of floor(words_written/4), saturating at Nr+1.
  - After the load edge it is 1/1/2 for 128/192/256.
  - It is monotonic within one expansion.
- Read port:
  - rk_o <= store[4*rk_idx_i .. 4*rk_idx_i+3] every cycle.
  - The value is defined only if rk_idx_i < rounds_ready_o at the sampling edge. Otherwise contents are unspecified, but the read must not X-propagate in simulation beyond rk_o.
  - Index > Nr yields unspecified data.
- SubWord uses four byte S-box instances (combinational), shared across all modes.
- Reset mid-EXPAND: next state IDLE, keys_valid_o=0, rounds_ready_o=0, and partial words are discarded logically.
- Simultaneous reset and start: reset wins.

Test Plan:
- AES-128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c:
  - keys_valid_o rises exactly 41 cycles after accept.
  - rk_idx_i=10 -> rk_o=d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - rk_idx_i=0 -> rk_o=key.
- AES-192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b:
  - Valid after 47 cycles.
  - rk_idx_i=12 -> rk_o=e98ba06f 448c773c 8ecc7204 01002202.
- AES-256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4:
  - Valid after 53 cycles.
  - rk_idx_i=14 -> rk_o=fe4890d1 e6188d0b 046df344 706c631e.
  - rounds_ready_o=2 one cycle after accept.
- Early read / handshake:
  - During the AES-128 run, start_ready_o=0 and a second start is ignored.
  - Reading round 1 as soon as rounds_ready_o>=2 returns a0fafe17 88542cb1 23a33939 2a6c7605.
- Start with mode_i=11 -> err_o pulses for 1 cycle, state stays IDLE, keys_valid_o stays 0.
- Assert reset_i 20 cycles into an AES-256 run -> next cycle keys_valid_o=0, rounds_ready_o=0, start_ready_o=1. A fresh AES-128 start then completes in 41 cycles with the correct round-10 key.
